// File: rtl/mcu_8bit_fetch_unit.sv
// mcu_8bit_fetch_unit
// Instruction-fetch stage of the 8-bit MCU. It owns the program counter,
// drives the instruction-memory address, and presents each fetched word
// together with its address to decode/execute.
//
// Optional feature: define FETCH_RET_STACK_EN to add a 4-entry
// return-address stack with call/return handling.
//
// Ports:
//   Clk            system clock, rising edge
//   Reset          synchronous active-high reset
//   resetPC        reset vector, loaded while Reset=1
//   i_stall        downstream busy; hold the presented instruction
//   i_load_pc      redirect request (jump / taken branch)
//   i_target_pc    redirect target
//   i_halt         stop fetching
//   i_call, i_ret  (FETCH_RET_STACK_EN) call with redirect / return
//   o_stack_err    (FETCH_RET_STACK_EN) sticky overflow/underflow flag
//   i_imem_data    instruction memory read data (1-cycle latency)
//   o_imem_addr    instruction memory address
//   o_instr        presented instruction (memory data passed through)
//   o_instr_valid  o_instr / currentPC valid this cycle
//   currentPC      address of the presented instruction
//   o_halted       high while halted
module mcu_8bit_fetch_unit #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [PC_W-1:0]    resetPC,
  input  logic               i_stall,
  input  logic               i_load_pc,
  input  logic [PC_W-1:0]    i_target_pc,
  input  logic               i_halt,
`ifdef FETCH_RET_STACK_EN
  input  logic               i_call,
  input  logic               i_ret,
  output logic               o_stack_err,
`endif
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic [PC_W-1:0]    o_imem_addr,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  output logic [PC_W-1:0]    currentPC,
  output logic               o_halted
);

  typedef enum logic [1:0] {S_START, S_RUN, S_BUBBLE, S_HALT} state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [PC_W-1:0] r_pc_q, r_pc_d;
  logic [PC_W-1:0] cur_pc_q, cur_pc_d;
  logic            valid_q, valid_d;

`ifdef FETCH_RET_STACK_EN
  logic [PC_W-1:0] stack_q [4];
  logic [PC_W-1:0] stack_d [4];
  logic [2:0]      sp_q, sp_d;      // number of occupied entries, 0..4
  logic [2:0]      sp_m1;
  logic            err_q, err_d;

  assign sp_m1       = sp_q - 3'd1;
  assign o_stack_err = err_q;
`endif

  always_comb begin
    state_d  = state_q;
    r_pc_d   = r_pc_q;
    cur_pc_d = cur_pc_q;
    valid_d  = valid_q;
`ifdef FETCH_RET_STACK_EN
    stack_d  = stack_q;
    sp_d     = sp_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_START, S_BUBBLE: begin
        if (state_q == S_BUBBLE && i_load_pc) begin
          // Back-to-back redirect: the newest target replaces the pending one.
          r_pc_d  = i_target_pc;
          valid_d = 1'b0;
        end else begin
          // The address issued this cycle returns data next cycle, so it
          // becomes the presented instruction then.
          cur_pc_d = r_pc_q;
          r_pc_d   = r_pc_q + PC_ONE;
          valid_d  = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (i_halt) begin
          valid_d = 1'b0;
          state_d = S_HALT;
        end else if (i_load_pc) begin
`ifdef FETCH_RET_STACK_EN
          if (i_call) begin
            if (sp_q == 3'd4) begin
              err_d = 1'b1;
            end else begin
              stack_d[sp_q[1:0]] = cur_pc_q + PC_ONE;
              sp_d               = sp_q + 3'd1;
            end
          end
`endif
          r_pc_d  = i_target_pc;
          valid_d = 1'b0;
          state_d = S_BUBBLE;
        end
`ifdef FETCH_RET_STACK_EN
        else if (i_ret && sp_q != 3'd0) begin
          r_pc_d  = stack_q[sp_m1[1:0]];
          sp_d    = sp_m1;
          valid_d = 1'b0;
          state_d = S_BUBBLE;
        end
`endif
        else if (i_stall) begin
          // Hold everything; the address mux re-reads the held instruction.
        end else begin
          cur_pc_d = r_pc_q;
          r_pc_d   = r_pc_q + PC_ONE;
          valid_d  = 1'b1;
        end
`ifdef FETCH_RET_STACK_EN
        // Return with an empty stack is flagged and otherwise ignored.
        if (!i_halt && !i_load_pc && i_ret && sp_q == 3'd0) begin
          err_d = 1'b1;
        end
`endif
      end
      S_HALT: begin
        valid_d = 1'b0;
        if (i_load_pc) begin
          r_pc_d  = i_target_pc;
          state_d = S_BUBBLE;
        end
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_START;
      r_pc_q   <= resetPC;
      cur_pc_q <= resetPC;
      valid_q  <= 1'b0;
`ifdef FETCH_RET_STACK_EN
      sp_q     <= 3'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      r_pc_q   <= r_pc_d;
      cur_pc_q <= cur_pc_d;
      valid_q  <= valid_d;
`ifdef FETCH_RET_STACK_EN
      sp_q     <= sp_d;
      err_q    <= err_d;
`endif
    end
  end

`ifdef FETCH_RET_STACK_EN
  // Stack contents need no reset: the occupancy count gates every read.
  always_ff @(posedge Clk) begin
    stack_q <= stack_d;
  end
`endif

  assign o_imem_addr   = (i_stall && valid_q) ? cur_pc_q : r_pc_q;
  assign o_instr       = i_imem_data;
  assign o_instr_valid = valid_q;
  assign currentPC     = cur_pc_q;
  assign o_halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_mcu_8bit_fetch_unit.sv
module tb_mcu_8bit_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  resetPC;
  logic        i_stall;
  logic        i_load_pc;
  logic [7:0]  i_target_pc;
  logic        i_halt;
  logic [15:0] i_imem_data;
  logic [7:0]  o_imem_addr;
  logic [15:0] o_instr;
  logic        o_instr_valid;
  logic [7:0]  currentPC;
  logic        o_halted;
`ifdef FETCH_RET_STACK_EN
  logic        i_call;
  logic        i_ret;
  logic        o_stack_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  mcu_8bit_fetch_unit #(.INSTR_W(16), .PC_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .resetPC(resetPC), .i_stall(i_stall),
    .i_load_pc(i_load_pc), .i_target_pc(i_target_pc), .i_halt(i_halt),
`ifdef FETCH_RET_STACK_EN
    .i_call(i_call), .i_ret(i_ret), .o_stack_err(o_stack_err),
`endif
    .i_imem_data(i_imem_data), .o_imem_addr(o_imem_addr), .o_instr(o_instr),
    .o_instr_valid(o_instr_valid), .currentPC(currentPC), .o_halted(o_halted)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  // Synchronous-read instruction memory
  always @(posedge Clk) i_imem_data <= mem_word(o_imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compare each presented instruction against the scoreboard;
  // the entry is retired once the instruction leaves the output.
  initial begin
    logic retire;
    forever begin
      @(negedge Clk);
      if (o_instr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got currentPC %h expected no valid instruction", currentPC);
        end else begin
          check("mon_pc", 32'(currentPC), 32'(exp_q[0]));
          check("mon_instr", 32'(o_instr), 32'(mem_word(exp_q[0])));
          retire = !i_stall || i_load_pc || i_halt;
`ifdef FETCH_RET_STACK_EN
          retire = retire || i_ret;
`endif
          if (retire) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; resetPC = 8'h10; i_stall = 1'b0; i_load_pc = 1'b0;
    i_target_pc = 8'h00; i_halt = 1'b0;
`ifdef FETCH_RET_STACK_EN
    i_call = 1'b0; i_ret = 1'b0;
`endif
    // Reset held for three edges
    repeat (3) step();
    check("rst_valid", 32'(o_instr_valid), 32'd0);
    check("rst_pc", 32'(currentPC), 32'h10);
    check("rst_halted", 32'(o_halted), 32'd0);
    Reset = 1'b0;
    check("start_addr", 32'(o_imem_addr), 32'h10);
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    step();
    check("run_addr_11", 32'(o_imem_addr), 32'h11);
    check("run_valid", 32'(o_instr_valid), 32'd1);
    step();
    check("run_addr_12", 32'(o_imem_addr), 32'h12);
    step();
    // Stall for three edges while 0x12 is presented
    i_stall = 1'b1;
    #1 check("stall_addr", 32'(o_imem_addr), 32'h12);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc", 32'(currentPC), 32'h12);
      check("stall_valid", 32'(o_instr_valid), 32'd1);
      check("stall_addr_held", 32'(o_imem_addr), 32'h12);
    end
    i_stall = 1'b0;
    exp_q.push_back(8'h13);
    step();
    check("after_stall_pc", 32'(currentPC), 32'h13);

    // Redirect from 0x05 to 0x40
    Reset = 1'b1; resetPC = 8'h05;
    step();
    Reset = 1'b0;
    exp_q.push_back(8'h05);
    step();
    i_load_pc = 1'b1; i_target_pc = 8'h40;
    exp_q.push_back(8'h40); exp_q.push_back(8'h41);
    step();
    i_load_pc = 1'b0;
    check("bubble_valid", 32'(o_instr_valid), 32'd0);
    check("bubble_addr", 32'(o_imem_addr), 32'h40);
    step();
    check("redir_pc", 32'(currentPC), 32'h40);
    step();
    check("redir_pc_next", 32'(currentPC), 32'h41);
    // Back-to-back redirect: newest target wins
    i_load_pc = 1'b1; i_target_pc = 8'h60;
    step();
    i_target_pc = 8'h70;
    exp_q.push_back(8'h70);
    step();
    i_load_pc = 1'b0;
    check("dbl_bubble_valid", 32'(o_instr_valid), 32'd0);
    check("dbl_bubble_addr", 32'(o_imem_addr), 32'h70);
    step();
    check("dbl_redir_pc", 32'(currentPC), 32'h70);

    // Wrap-around from 0xFE
    Reset = 1'b1; resetPC = 8'hFE;
    step();
    Reset = 1'b0;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    step();
    for (int k = 0; k < 4; k++) begin
      check("wrap_valid", 32'(o_instr_valid), 32'd1);
      check("wrap_pc", 32'(currentPC), 32'((8'hFE + k) & 8'hFF));
      if (k == 3) begin
        Reset = 1'b1; resetPC = 8'h07;
      end
      step();
    end

    // Halt at 0x07
    Reset = 1'b0;
    exp_q.push_back(8'h07);
    step();
    i_halt = 1'b1;
    step();
    i_stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("halt_flag", 32'(o_halted), 32'd1);
      check("halt_valid", 32'(o_instr_valid), 32'd0);
      check("halt_addr", 32'(o_imem_addr), 32'h08);
      step();
    end
    i_halt = 1'b0; i_stall = 1'b0; i_load_pc = 1'b1; i_target_pc = 8'h20;
    exp_q.push_back(8'h20);
    step();
    i_load_pc = 1'b0;
    check("unhalt_flag", 32'(o_halted), 32'd0);
    check("unhalt_valid", 32'(o_instr_valid), 32'd0);
    check("unhalt_addr", 32'(o_imem_addr), 32'h20);
    step();
    check("unhalt_pc", 32'(currentPC), 32'h20);
    Reset = 1'b1;
    step();

`ifdef FETCH_RET_STACK_EN
    // Five nested calls, then five returns
    resetPC = 8'h10;
    step();
    Reset = 1'b0;
    exp_q.push_back(8'h10);
    step();
    for (int k = 0; k < 5; k++) begin
      logic [7:0] tgt;
      tgt = 8'h20 + 8'(k * 16);
      i_call = 1'b1; i_load_pc = 1'b1; i_target_pc = tgt;
      exp_q.push_back(tgt);
      step();
      i_call = 1'b0; i_load_pc = 1'b0;
      check("call_err", 32'(o_stack_err), (k == 4) ? 32'd1 : 32'd0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ra;
      ra = 8'h41 - 8'(k * 16);
      i_ret = 1'b1;
      exp_q.push_back(ra);
      step();
      i_ret = 1'b0;
      check("ret_bubble", 32'(o_instr_valid), 32'd0);
      step();
      check("ret_pc", 32'(currentPC), 32'(ra));
    end
    i_ret = 1'b1;
    exp_q.push_back(8'h12);
    step();
    i_ret = 1'b0;
    check("underflow_valid", 32'(o_instr_valid), 32'd1);
    check("underflow_pc", 32'(currentPC), 32'h12);
    check("underflow_err", 32'(o_stack_err), 32'd1);
    Reset = 1'b1;
    step();
    check("err_cleared", 32'(o_stack_err), 32'd0);
`endif

    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
